// File: rtl/kamus_mem_arbiter.sv
// kamus_mem_arbiter: round-robin IF/LSU arbiter for one memory bus, one outstanding transaction
//   clk_i, rst_i : clock, synchronous active-high reset
//   if_*         : fetch port, req/addr in; gnt, rvalid, rdata, err out
//   lsu_*        : load/store port, req/we/width/addr/wdata in; gnt, rvalid, rdata, err out
//   mem_*        : memory bus, word-aligned addr, byte enables, lane-replicated wdata, gnt/rvalid/rdata in
module kamus_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_width_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;
    localparam logic [15:0] TMO = 16'(TIMEOUT);
    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        lsu_win, if_win, lsu_bad, resp_v, resp_err;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_wd;
    // owner_q and rr_q: 1 = LSU; rr_q names the requester preferred on the next tie
    always_comb begin
        lsu_win = lsu_req_i & (rr_q | ~if_req_i);
        if_win = if_req_i & ~lsu_win;
        lsu_bad = (lsu_width_i == 2'b11) || (lsu_width_i == 2'b10 && lsu_addr_i[1:0] != 2'b00)
                  || (lsu_width_i == 2'b01 && lsu_addr_i[0]);
        lsu_be = lsu_width_i == 2'b10 ? 4'b1111 :
                 lsu_width_i == 2'b01 ? 4'b0011 << {lsu_addr_i[1], 1'b0} :
                 lsu_width_i == 2'b00 ? 4'b0001 << lsu_addr_i[1:0] : 4'b0000;
        lsu_wd = lsu_width_i == 2'b00 ? {4{lsu_wdata_i[7:0]}} :
                 lsu_width_i == 2'b01 ? {2{lsu_wdata_i[15:0]}} : lsu_wdata_i;
    end
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d = rr_q;
        cnt_d = cnt_q;
        we_d = we_q;
        be_d = be_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        if_gnt_o = 1'b0;
        lsu_gnt_o = 1'b0;
        resp_v = 1'b0;
        resp_err = 1'b0;
        case (state_q)
            IDLE: if (lsu_win | if_win) begin
                if_gnt_o = if_win;
                lsu_gnt_o = lsu_win;
                owner_d = lsu_win;
                rr_d = ~lsu_win;
                we_d = lsu_win & lsu_we_i;
                be_d = lsu_win ? lsu_be : 4'b1111;
                addr_d = {lsu_win ? lsu_addr_i[31:2] : if_addr_i[31:2], 2'b00};
                wdata_d = lsu_win ? lsu_wd : 32'h0;
                state_d = (lsu_win ? lsu_bad : if_addr_i[1:0] != 2'b00) ? ERR : REQ;
            end
            REQ: if (mem_gnt_i) begin
                state_d = RESP;
                cnt_d = 16'h0;
            end
            RESP: begin
                resp_v = mem_rvalid_i | (cnt_q == TMO);
                resp_err = resp_v & ~mem_rvalid_i;
                state_d = resp_v ? IDLE : RESP;
                cnt_d = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
            end
            ERR: begin
                resp_v = 1'b1;
                resp_err = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q <= 1'b1;
            cnt_q <= 16'h0;
            we_q <= 1'b0;
            be_q <= 4'h0;
            addr_q <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
            we_q <= we_d;
            be_q <= be_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
        end
    end
    always_comb begin
        if_rvalid_o = resp_v & ~owner_q;
        lsu_rvalid_o = resp_v & owner_q;
        if_err_o = resp_err & ~owner_q;
        lsu_err_o = resp_err & owner_q;
        if_rdata_o = (if_rvalid_o & ~resp_err) ? mem_rdata_i : 32'h0;
        lsu_rdata_o = (lsu_rvalid_o & ~resp_err) ? mem_rdata_i : 32'h0;
        mem_req_o = state_q == REQ;
        mem_we_o = we_q;
        mem_be_o = be_q;
        mem_addr_o = addr_q;
        mem_wdata_o = wdata_q;
    end
endmodule

// File: doc/kamus_mem_arbiter.md
# kamus_mem_arbiter

Shares the single memory bus between the kamus-v instruction-fetch stage (IF) and the load/store unit (LSU). Arbitrates round-robin, allows one outstanding transaction, and converts LSU `mem_width_e` accesses into word-aligned address and byte-enable form. Rejects misaligned accesses locally with an error response. Times out unanswered memory transactions. Sits between the core pipeline and the external instruction/data memory port.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles waited in RESP for `mem_rvalid_i` before an error response is returned (range 1..65535).

Ports:
- `clk_i` in 1: clock, the only clock in the block.
- `rst_i` in 1: reset, synchronous, active-high.
- `if_req_i` in 1: IF read request; held with its address until granted.
- `if_addr_i` in 32: IF byte address.
- `if_gnt_o` out 1: IF request accepted this cycle.
- `if_rvalid_o` out 1: IF response valid; one-cycle pulse.
- `if_rdata_o` out 32: IF read word.
- `if_err_o` out 1: IF response is an error; qualified by `if_rvalid_o`.
- `lsu_req_i` in 1: LSU request; held with all its attributes until granted.
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_width_i` in 2: `mem_width_e` (B=00, H=01, W=10; 11 is illegal).
- `lsu_addr_i` in 32: LSU byte address.
- `lsu_wdata_i` in 32: store data, right-aligned.
- `lsu_gnt_o` out 1: LSU request accepted this cycle.
- `lsu_rvalid_o` out 1: LSU response valid; used for loads and store acks.
- `lsu_rdata_o` out 32: raw memory word; the LSU does the byte/half extraction.
- `lsu_err_o` out 1: LSU response is an error; qualified by `lsu_rvalid_o`.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: memory write enable.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word-aligned address, equal to {addr[31:2],2'b00}.
- `mem_wdata_o` out 32: lane-replicated write data.
- `mem_gnt_i` in 1: memory accepted the request.
- `mem_rvalid_i` in 1: memory response; writes are acknowledged too.
- `mem_rdata_i` in 32: memory read data.

## Operation
- The FSM has four states: IDLE, REQ, RESP, ERR. The `owner` register records which requester holds the transaction.
- **IDLE arbitration:**
  - With one requester, that requester wins.
  - With both requesting, the requester that did not win the last grant wins.
  - The round-robin pointer favours the LSU after reset.
  - The winner gets a combinational `*_gnt_o` pulse in the same cycle. Address, we, be and wdata are latched.
- **Alignment check at grant:**
  - IF: addr[1:0] must be 00.
  - LSU H: addr[0] must be 0.
  - LSU W: addr[1:0] must be 00.
  - LSU width 11 is always illegal.
  - Any violation → ERR, with no memory access. Otherwise → REQ.
- **Byte enables:** W → 1111; H → 0011 << (2*addr[1]); B → 0001 << addr[1:0]; IF → 1111.
- **Write data:** B replicates wdata[7:0] to all 4 lanes; H replicates wdata[15:0] to both halves; W passes wdata through.
- **REQ:** `mem_req_o`=1 with latched attributes, held stable until `mem_gnt_i`. `mem_gnt_i` → RESP, timeout counter cleared.
- **RESP:**
  - `mem_rvalid_i` → owner's `*_rvalid_o`=1 and `*_rdata_o`=`mem_rdata_i` in the same cycle (combinational), err=0 → IDLE.
  - Counter reaches TIMEOUT first → owner's rvalid=1, err=1, rdata=0 → IDLE.
- **ERR:** one cycle; owner's rvalid=1, err=1, rdata=0 → IDLE.
- `mem_rvalid_i` in IDLE or REQ (late or stray) is ignored. Only one transaction is ever outstanding.
- A requester not holding the bus sees rvalid=0 and err=0. Its rdata is don't-care; it is driven 0.

## Timing
- **Reset value of every output:** all outputs 0.
- **Reset state:** FSM=IDLE, RR pointer=LSU, counter=0, latched registers=0.
- **Reset mid-transaction:** the transaction is abandoned with no response to the requester. A later `mem_rvalid_i` is ignored.
- **Nominal latency, with grant at cycle 0 and zero-wait memory:**
  - `mem_req_o` at cycle 1; `mem_gnt_i` at cycle 1.
  - RESP from cycle 2; `mem_rvalid_i` at cycle 2 → `*_rvalid_o` at cycle 2.
  - Next grant possible at cycle 3.
- **Error latency:** grant at cycle 0 → error rvalid at cycle 1 → IDLE at cycle 2.
- **Timeout:** error rvalid in the cycle the counter equals TIMEOUT (TIMEOUT+1 cycles in RESP). The counter saturates and does not wrap.
- `*_gnt_o` and `*_rvalid_o` are never asserted simultaneously for the same requester. Grants occur only in IDLE.

## Test plan
- **Single fetch:** IF req addr 0x100; memory grants immediately and returns 0xDEADBEEF next cycle → `if_gnt_o` at c0, `mem_req_o`/`mem_addr_o`=0x100/`mem_be_o`=1111 at c1, `if_rvalid_o` with 0xDEADBEEF at c2.
- **Contention:** IF and LSU both request continuously after reset → grant order LSU, IF, LSU, IF; each response is routed only to its owner.
- **Store byte lanes:**
  - SB addr 0x203, wdata 0x000000AB → be=1000, `mem_wdata_o`=0xABABABAB, addr 0x200.
  - SH addr 0x202, wdata 0x1234 → be=1100, wdata=0x12341234.
- **Misaligned:** LSU LW addr 0x201 → gnt at c0, `lsu_rvalid_o`+`lsu_err_o` at c1, `mem_req_o` never asserted. Repeat for LH addr 0x3 and for width 11.
- **Timeout:** TIMEOUT=4, memory grants but never responds → err response after 5 RESP cycles. A stray `mem_rvalid_i` arriving later in IDLE produces no output.
- **Reset mid-RESP:** assert `rst_i` while waiting for rvalid, then deliver `mem_rvalid_i` → no `*_rvalid_o`, all outputs 0, next grant goes to the LSU.
